int_rs_age_scheduler: RTL and testbench
=======================================

Name: int_rs_age_scheduler

Overview:
Control and select logic for the integer reservation station array of N rs_entry instances.
- Allocates a free entry slot for each dispatched uop and drives that entry's push_en.
- Tracks relative age of all entries with an age matrix.
- Each cycle, grants the oldest requesting entry to the integer ALU issue port.
- Sits between rename/dispatch and the entry array; the grant feeds each entry's grant input and the issue mux select.

Parameters:
RS_DEPTH, 8, number of reservation station entries (power of two, >= 2)
RS_IDX_W, $clog2(RS_DEPTH), entry index width
CNT_W, $clog2(RS_DEPTH)+1, occupancy counter width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
flush  input  1  pipeline flush (mispredict/exception)
dispatch_valid  input  1  dispatch offers a uop this cycle
dispatch_ready  output  1  a free entry exists and no flush
entry_valid  input  RS_DEPTH  valid output of each entry
entry_request  input  RS_DEPTH  request output of each entry
push_en  output  RS_DEPTH  one-hot push to selected free entry
clear  output  RS_DEPTH  per-entry clear (all bits = flush)
fu_ready  input  1  ALU can accept an issue this cycle
grant  output  RS_DEPTH  one-hot grant to oldest requester
issue_valid  output  1  a grant is asserted
issue_idx  output  RS_IDX_W  binary index of granted entry
occupancy  output  CNT_W  registered count of valid entries

Behaviour:
- Reset (async): age matrix all 0, occupancy 0. All combinational outputs follow from inputs; with entries invalid: dispatch_ready=1, grant=0, issue_valid=0.
- Free vector: free[i] = !entry_valid[i]. A slot granted this cycle is not reusable until the next cycle (no same-cycle recycle).
- Allocation:
  - Lowest-index free slot k.
  - dispatch_ready = |free && !flush.
  - push_en[k] = dispatch_valid && dispatch_ready; all other push_en bits are 0.
- Age matrix: age[i][j]=1 means i is older than j; diagonal unused.
  - On push into k at the clock edge: row k cleared (k younger than every entry); column k set for all i != k (every other entry older than k).
  - A stale column or row belonging to an invalid entry is harmless, because only requesting entries are compared.
- Select (combinational, zero latency):
  - win[i] = entry_request[i] && no j != i with entry_request[j] && age[j][i].
  - Exactly one winner exists whenever any request is set.
  - grant = win & {RS_DEPTH{fu_ready && !flush}}.
  - issue_valid = |grant; issue_idx = encode(grant).
- Simultaneous push and grant: both take effect.
  - The pushed entry is youngest and cannot request in the cycle it is pushed, since its entry_valid is still 0.
  - Age update uses only the push; grant causes no matrix change.
- Occupancy update:
  - +1 on push, -1 on grant, unchanged on both.
  - Flush sets it to 0 next cycle; flush has priority over all other updates.
- Flush:
  - clear asserted to all entries the same cycle.
  - No push, no grant.
  - Age matrix reset to 0 next cycle.
  - Reset asserted mid-cycle overrides everything asynchronously.
- Full (occupancy == RS_DEPTH): dispatch_ready=0 even if a grant frees an entry this cycle.
- Invariant (bench assertion): occupancy == popcount(entry_valid) every cycle outside reset.
- Invariant: grant is one-hot or zero.

Decomposition:
- Shared package int_rs_types gains:
  - RS_DEPTH/RS_IDX_W constants.
  - rs_idx_t (logic [RS_IDX_W-1:0]).
  - rs_vec_t (logic [RS_DEPTH-1:0]).
- Sub-module rs_age_matrix:
  - Holds age storage, push update and flush reset.
  - Outputs the per-entry oldest-winner vector given a request vector.
  - Reusable for the memory RS.
- Allocation priority encoder and occupancy counter stay in the top module.

Test Plan:
- Reset then fill: dispatch_valid=1 for 8 cycles, no requests -> push_en = 0x01,0x02,...,0x80; occupancy 8; dispatch_ready=0 in cycle 9.
- Age order: push into slots 0,1,2 in that order, then raise requests on 2 and 1 with fu_ready=1 -> grant=0x02, next cycle grant=0x04.
- Recycle: fill slots 0..7, grant slot 3, free it, then push one uop -> push_en=0x08. That uop loses to an older request on slot 5 (grant=0x20).
- Simultaneous push/grant at occupancy 4: push and grant the same cycle -> occupancy stays 4, pushed slot is the lowest free slot excluding the granted one.
- fu_ready=0 with requests on 0x0F -> grant=0, issue_valid=0, occupancy unchanged; fu_ready=1 -> grant = oldest of the four.
- Flush with 5 valid entries and dispatch_valid=1 -> clear=0xFF, push_en=0, grant=0, dispatch_ready=0; next cycle occupancy 0 and age matrix zero. Async rst mid-fill -> occupancy 0 immediately.

Source files
------------

// File: rtl/int_rs_types.sv
// Shared integer reservation-station types and sizing constants.
package int_rs_types;

  localparam int RS_DEPTH = 8;
  localparam int RS_IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W    = RS_IDX_W + 1;

  typedef logic [RS_IDX_W-1:0] rs_idx_t;
  typedef logic [RS_DEPTH-1:0] rs_vec_t;

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: age_q[i][j]=1 means entry i is older than entry j.
// Picks the single oldest entry among a request vector. Shared with the memory RS.
module rs_age_matrix #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  input  logic [IDX_W-1:0] push_idx,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     oldest
);

  logic [N-1:0][N-1:0] age_q, age_d;

  // Next state: a pushed entry becomes younger than everyone; flush wipes history.
  // The column set comes before the row clear so the diagonal always stays 0,
  // which lets the select below skip an explicit j != i test.
  always_comb begin
    age_d = age_q;
    if (flush) begin
      age_d = '0;
    end else if (push_valid) begin
      for (int i = 0; i < N; i++) begin
        age_d[i][push_idx] = 1'b1;
        age_d[push_idx][i] = 1'b0;
      end
    end
  end

  // Age storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end

  // A requester wins unless some other requester is older than it.
  // Stale rows/columns of invalid entries never matter: only requesters are compared.
  always_comb begin
    oldest = '0;
    for (int i = 0; i < N; i++) begin
      oldest[i] = req[i];
      for (int j = 0; j < N; j++)
        if (req[j] && age_q[j][i]) oldest[i] = 1'b0;
    end
  end

endmodule

// File: rtl/int_rs_age_scheduler.sv
// Integer RS control: free-slot allocation, oldest-first issue select,
// and the occupancy counter for the entry array.
module int_rs_age_scheduler #(
  parameter int RS_DEPTH = int_rs_types::RS_DEPTH,
  parameter int RS_IDX_W = $clog2(RS_DEPTH),
  parameter int CNT_W    = $clog2(RS_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                dispatch_valid,
  output logic                dispatch_ready,
  input  logic [RS_DEPTH-1:0] entry_valid,
  input  logic [RS_DEPTH-1:0] entry_request,
  output logic [RS_DEPTH-1:0] push_en,
  output logic [RS_DEPTH-1:0] clear,
  input  logic                fu_ready,
  output logic [RS_DEPTH-1:0] grant,
  output logic                issue_valid,
  output logic [RS_IDX_W-1:0] issue_idx,
  output logic [CNT_W-1:0]    occupancy
);

  logic [RS_DEPTH-1:0] free;
  logic [RS_DEPTH-1:0] win;
  logic [RS_IDX_W-1:0] alloc_idx;
  logic                push_fire;
  logic                issue_ok;
  logic [CNT_W-1:0]    occ_q, occ_d;

  // Lowest-index free slot. Free comes straight from entry_valid, so an entry
  // granted this cycle still looks busy and is only reusable next cycle.
  always_comb begin
    free      = ~entry_valid;
    alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (free[i]) alloc_idx = RS_IDX_W'(i);
  end

  assign dispatch_ready = (|free) && !flush;
  assign push_fire      = dispatch_valid && dispatch_ready;
  assign push_en        = push_fire ? (RS_DEPTH'(1) << alloc_idx) : '0;
  assign clear          = {RS_DEPTH{flush}};

  rs_age_matrix #(
    .N     (RS_DEPTH),
    .IDX_W (RS_IDX_W)
  ) u_age (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_fire),
    .push_idx   (alloc_idx),
    .req        (entry_request),
    .oldest     (win)
  );

  assign issue_ok    = fu_ready && !flush;
  assign grant       = win & {RS_DEPTH{issue_ok}};
  assign issue_valid = |grant;

  // Binary encode of the one-hot grant (0 when nothing is granted).
  always_comb begin
    issue_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      if (grant[i]) issue_idx = issue_idx | RS_IDX_W'(i);
  end

  // Occupancy next state: flush wins; push and grant together cancel out.
  always_comb begin
    occ_d = occ_q;
    if (flush)                          occ_d = '0;
    else if (push_fire && !issue_valid) occ_d = occ_q + CNT_W'(1);
    else if (!push_fire && issue_valid) occ_d = occ_q - CNT_W'(1);
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_int_rs_age_scheduler.sv
// Directed bench for int_rs_age_scheduler. The entry array is modelled by a
// valid vector updated from the expected push/grant of each step.
module tb_int_rs_age_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       dispatch_valid;
  logic       dispatch_ready;
  logic [7:0] entry_valid;
  logic [7:0] entry_request;
  logic [7:0] push_en;
  logic [7:0] clear;
  logic       fu_ready;
  logic [7:0] grant;
  logic       issue_valid;
  logic [2:0] issue_idx;
  logic [3:0] occupancy;

  int_rs_types::rs_vec_t ev;
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic       fl;
    logic       dv;
    logic [7:0] rq;
    logic       fu;
    logic [7:0] ep;
    logic [7:0] eg;
    logic       er;
    int         eo;
  } vec_t;

  vec_t tbl[19];

  int_rs_age_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .dispatch_valid (dispatch_valid),
    .dispatch_ready (dispatch_ready),
    .entry_valid    (entry_valid),
    .entry_request  (entry_request),
    .push_en        (push_en),
    .clear          (clear),
    .fu_ready       (fu_ready),
    .grant          (grant),
    .issue_valid    (issue_valid),
    .issue_idx      (issue_idx),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One cycle: drive at negedge, check combinational and registered outputs,
  // then advance the entry model past the rising edge.
  task automatic step(input logic fl, input logic dv, input logic [7:0] rq, input logic fu,
                      input logic [7:0] ep, input logic [7:0] eg, input logic er,
                      input int eo, input string nm);
    int ei;
    @(negedge clk);
    flush = fl; dispatch_valid = dv; entry_request = rq; fu_ready = fu; entry_valid = ev;
    #1;
    chk({nm, ".push_en"}, push_en, ep);
    chk({nm, ".grant"}, grant, eg);
    chk({nm, ".ready"}, dispatch_ready, er);
    chk({nm, ".occ"}, occupancy, eo);
    chk({nm, ".clear"}, clear, {8{fl}});
    chk({nm, ".issue_valid"}, issue_valid, (eg != 8'h00));
    chk({nm, ".occ_vs_valid"}, occupancy, $countones(ev));
    chk({nm, ".grant_onehot0"}, $onehot0(grant), 1'b1);
    if (eg != 8'h00) begin
      ei = 0;
      for (int i = 0; i < 8; i++) if (eg[i]) ei = i;
      chk({nm, ".issue_idx"}, issue_idx, ei);
    end
    @(posedge clk); #1;
    ev = fl ? 8'h00 : ((ev | ep) & ~eg);
    entry_valid = ev;
  endtask

  function automatic vec_t mk(logic fl, logic dv, logic [7:0] rq, logic fu,
                              logic [7:0] ep, logic [7:0] eg, logic er, int eo);
    vec_t v;
    v.fl = fl; v.dv = dv; v.rq = rq; v.fu = fu; v.ep = ep; v.eg = eg; v.er = er; v.eo = eo;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill, recycle, fu_ready stall, push+grant, flush.
    tbl[0] = mk(0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] oh;
      oh = 8'h01 << (i - 1);
      tbl[i] = mk(0, 1, 8'h00, 0, oh, 8'h00, 1, i - 1);
    end
    tbl[9]  = mk(0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 8);  // full
    tbl[10] = mk(0, 0, 8'h0F, 0, 8'h00, 8'h00, 0, 8);  // fu not ready
    tbl[11] = mk(0, 0, 8'h08, 1, 8'h00, 8'h08, 0, 8);  // issue slot 3
    tbl[12] = mk(0, 1, 8'h00, 0, 8'h08, 8'h00, 1, 7);  // refill slot 3
    tbl[13] = mk(0, 0, 8'h28, 1, 8'h00, 8'h20, 0, 8);  // slot 5 older than new 3
    tbl[14] = mk(0, 0, 8'h0F, 0, 8'h00, 8'h00, 1, 7);
    tbl[15] = mk(0, 0, 8'h0F, 1, 8'h00, 8'h01, 1, 7);  // 3 is youngest now
    tbl[16] = mk(0, 1, 8'h0E, 1, 8'h01, 8'h02, 1, 6);  // push + grant
    tbl[17] = mk(1, 1, 8'h0C, 1, 8'h00, 8'h00, 0, 6);  // flush
    tbl[18] = mk(0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0);

    rst = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; entry_request = '0;
    fu_ready = 1'b0; ev = '0; entry_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.occ", occupancy, 0);
    chk("reset.ready", dispatch_ready, 1'b1);
    chk("reset.grant", grant, 8'h00);
    chk("reset.issue_valid", issue_valid, 1'b0);
    @(negedge clk); rst = 1'b0;

    for (int t = 0; t < 19; t++)
      step(tbl[t].fl, tbl[t].dv, tbl[t].rq, tbl[t].fu, tbl[t].ep, tbl[t].eg,
           tbl[t].er, tbl[t].eo, $sformatf("vec%0d", t));

    // Age order: push 0,1,2, request 2 and 1 -> 1 first, then 2.
    step(0, 1, 8'h00, 0, 8'h01, 8'h00, 1, 0, "age.p0");
    step(0, 1, 8'h00, 0, 8'h02, 8'h00, 1, 1, "age.p1");
    step(0, 1, 8'h00, 0, 8'h04, 8'h00, 1, 2, "age.p2");
    step(0, 0, 8'h06, 1, 8'h00, 8'h02, 1, 3, "age.g1");
    step(0, 0, 8'h04, 1, 8'h00, 8'h04, 1, 2, "age.g2");
    // Build occupancy 4 then push and grant in one cycle.
    step(0, 1, 8'h00, 0, 8'h02, 8'h00, 1, 1, "sim.p1");
    step(0, 1, 8'h00, 0, 8'h04, 8'h00, 1, 2, "sim.p2");
    step(0, 1, 8'h00, 0, 8'h08, 8'h00, 1, 3, "sim.p3");
    step(0, 1, 8'h01, 1, 8'h10, 8'h01, 1, 4, "sim.pg");
    step(0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 4, "sim.after");
    // Flush with 5 valid entries and a dispatch pending.
    step(0, 1, 8'h00, 0, 8'h01, 8'h00, 1, 4, "fl.p0");
    step(1, 1, 8'h1F, 1, 8'h00, 8'h00, 0, 5, "fl.flush");
    step(0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, "fl.after");
    step(0, 1, 8'h00, 0, 8'h01, 8'h00, 1, 0, "fl.p0b");
    step(0, 1, 8'h00, 0, 8'h02, 8'h00, 1, 1, "fl.p1b");
    step(0, 0, 8'h03, 1, 8'h00, 8'h01, 1, 2, "fl.g0");
    // Async reset between clock edges.
    step(0, 1, 8'h00, 0, 8'h01, 8'h00, 1, 1, "ar.p0");
    @(negedge clk);
    dispatch_valid = 1'b0;
    #1;
    chk("ar.occ_before", occupancy, 2);
    #1; rst = 1'b1;
    #1;
    chk("ar.occ_async", occupancy, 0);
    ev = '0; entry_valid = '0;
    #1; rst = 1'b0;
    step(0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, "ar.after");
    step(0, 1, 8'h00, 0, 8'h01, 8'h00, 1, 0, "ar.p0b");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
